// File: rtl/key_entry_buffer.sv
// Three-digit BCD guess entry buffer driven by single debounced key presses.
// Optional build macro: KEY_ENTRY_AUTO_COMMIT_EN (digit on a full buffer commits it).
module key_entry_buffer #(
  parameter logic [11:0] SECRET    = 12'h357,
  parameter logic [3:0]  MAX_TRIES = 4'd9
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic [15:0] key_deb,
  output logic [11:0] data,
  output logic [3:0]  tries,
  output logic [1:0]  result,
  output logic        commit,
  output logic        locked
);

  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_ENTER     = 4'd10;
  localparam logic [3:0] KEY_BACK      = 4'd11;
  localparam logic [3:0] KEY_CLEAR     = 4'd12;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_LOW  = 2'b01;
  localparam logic [1:0] RES_HIGH = 2'b10;
  localparam logic [1:0] RES_EQ   = 2'b11;

  typedef enum logic [0:0] {ST_ENTRY = 1'b0, ST_DONE = 1'b1} state_t;

  state_t      state_r;
  logic [15:0] prev_key_r;
  logic [11:0] data_r;
  logic [1:0]  count_r;
  logic [3:0]  tries_r;
  logic [1:0]  result_r;
  logic        commit_r;
  logic        locked_r;

  logic [3:0]  key_idx_s;
  logic        onehot_s;
  logic        press_s;
  logic        digit_s;
  logic        auto_s;
  logic        commit_now_s;
  logic [1:0]  cmp_s;

  // Decode which single key is held; multi-key vectors are never presses.
  always_comb begin
    onehot_s = (key_deb != 16'h0000) && ((key_deb & (key_deb - 16'h0001)) == 16'h0000);
    case (key_deb)
      16'h0001: key_idx_s = 4'd0;
      16'h0002: key_idx_s = 4'd1;
      16'h0004: key_idx_s = 4'd2;
      16'h0008: key_idx_s = 4'd3;
      16'h0010: key_idx_s = 4'd4;
      16'h0020: key_idx_s = 4'd5;
      16'h0040: key_idx_s = 4'd6;
      16'h0080: key_idx_s = 4'd7;
      16'h0100: key_idx_s = 4'd8;
      16'h0200: key_idx_s = 4'd9;
      16'h0400: key_idx_s = 4'd10;
      16'h0800: key_idx_s = 4'd11;
      16'h1000: key_idx_s = 4'd12;
      16'h2000: key_idx_s = 4'd13;
      16'h4000: key_idx_s = 4'd14;
      16'h8000: key_idx_s = 4'd15;
      default:  key_idx_s = 4'd0;
    endcase
  end

  // Press qualification, commit decision and guess comparison.
  always_comb begin
    press_s = (prev_key_r == 16'h0000) && onehot_s;
    digit_s = (key_idx_s <= KEY_DIGIT_MAX);
`ifdef KEY_ENTRY_AUTO_COMMIT_EN
    auto_s = digit_s && (count_r == 2'd3);
`else
    auto_s = 1'b0;
`endif
    commit_now_s = press_s && (state_r == ST_ENTRY) &&
                   (((key_idx_s == KEY_ENTER) && (count_r != 2'd0)) || auto_s);
    if (data_r < SECRET) begin
      cmp_s = RES_LOW;
    end else if (data_r > SECRET) begin
      cmp_s = RES_HIGH;
    end else begin
      cmp_s = RES_EQ;
    end
  end

  // Game state, entry buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      state_r    <= ST_ENTRY;
      prev_key_r <= 16'hFFFF;
      data_r     <= 12'h000;
      count_r    <= 2'd0;
      tries_r    <= 4'd0;
      result_r   <= RES_NONE;
      commit_r   <= 1'b0;
      locked_r   <= 1'b0;
    end else begin
      prev_key_r <= key_deb;
      commit_r   <= 1'b0;
      if (commit_now_s) begin
        commit_r <= 1'b1;
        tries_r  <= (tries_r < MAX_TRIES) ? (tries_r + 4'd1) : MAX_TRIES;
        result_r <= cmp_s;
        if (cmp_s == RES_EQ) begin
          state_r  <= ST_DONE;
          locked_r <= 1'b1;
        end else begin
          data_r  <= 12'h000;
          count_r <= 2'd0;
        end
      end else if (press_s) begin
        case (state_r)
          ST_ENTRY: begin
            if (digit_s) begin
              if (count_r != 2'd3) begin
                data_r  <= {data_r[7:0], key_idx_s};
                count_r <= count_r + 2'd1;
              end
            end else if (key_idx_s == KEY_BACK) begin
              if (count_r != 2'd0) begin
                data_r  <= {4'h0, data_r[11:4]};
                count_r <= count_r - 2'd1;
              end
            end else if (key_idx_s == KEY_CLEAR) begin
              data_r  <= 12'h000;
              count_r <= 2'd0;
            end
          end
          ST_DONE: begin
            if (key_idx_s == KEY_CLEAR) begin
              state_r  <= ST_ENTRY;
              data_r   <= 12'h000;
              count_r  <= 2'd0;
              tries_r  <= 4'd0;
              result_r <= RES_NONE;
              locked_r <= 1'b0;
            end
          end
          default: begin
            state_r  <= ST_ENTRY;
            locked_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data   = data_r;
  assign tries  = tries_r;
  assign result = result_r;
  assign commit = commit_r;
  assign locked = locked_r;

endmodule

// File: doc/key_entry_buffer.md
# key_entry_buffer

Consumes the 16-bit debounced key-level vector from the key filter and turns single key presses into a three-digit BCD entry buffer for a number-guessing game. It sits between the key filter and the seven-segment time/digit display module. It supplies the displayed value, the guess/try count and the compare result against a fixed secret. All state updates are edge-triggered on new presses; held keys never repeat.

## Interface
- SECRET, 12'h357, target value as three packed BCD digits; each nibble must be 0-9.
- MAX_TRIES, 4'd9, saturation value of the try counter; the display shows one digit.
- clk  input  1  system clock, 50 MHz.
- RSTn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- key_deb  input  16  debounced key levels; bit k high while key k is held.
- data  output  12  entry buffer {d2,d1,d0}, BCD, d0 is the most recent digit.
- tries  output  4  number of committed guesses, binary 0..MAX_TRIES.
- result  output  2  00 none, 01 guess low, 10 guess high, 11 equal.
- commit  output  1  one-cycle pulse on each accepted guess.
- locked  output  1  high in state DONE.

## Operation
- Press detect: register prev_key <= key_deb every cycle. A press of key k occurs in a cycle where prev_key == 0 and key_deb == (1<<k).
  - A multi-bit key_deb is never a press. A transition from one key directly to another is not a press.
- Key map: 0-9 digit; 10 ENTER; 11 BACKSPACE; 12 CLEAR; 13-15 ignored.
- Internal count, 0..3, holds the number of digits entered.
- FSM states: ENTRY (reset state) and DONE.
- ENTRY, digit v:
  - If count < 3: data <= {d1,d0,v} and count+1.
  - If count == 3: ignored, unless the auto-commit option is enabled (see Configuration).
- ENTRY, BACKSPACE:
  - If count > 0: data <= {4'h0,d2,d1} and count-1.
  - If count == 0: no-op.
- ENTRY, ENTER:
  - If count == 0: ignored.
  - Otherwise:
    - commit = 1 for one cycle.
    - tries <= min(tries+1, MAX_TRIES).
    - result from an unsigned compare of data against SECRET. Packed BCD with leading zeros orders the same as binary.
  - On equal: go to DONE and data holds the guess.
  - Otherwise: data <= 0 and count <= 0.
- ENTRY, CLEAR: data <= 0 and count <= 0. tries and result are kept.
- DONE: every key except CLEAR is ignored. CLEAR clears data, count, tries and result, then goes to ENTRY (new game).
- At MAX_TRIES, further commits still compare and pulse commit; tries stays at MAX_TRIES.

## Timing
- Reset values:
  - data = 0, tries = 0, result = 00, commit = 0, locked = 0.
  - state ENTRY, count 0.
  - prev_key = 16'hFFFF, so a key held through reset must be released before it counts.
- Latency: a press seen at edge n updates data, tries, result, commit and locked after edge n. Outputs are registered, with no combinational path from key_deb.
- commit is high for exactly one cycle per accepted ENTER.
- A held key produces exactly one press. Re-pressing needs at least one cycle of key_deb == 0.
- Reset asserted mid-game forces the reset values at the same edge, regardless of key_deb.

## Configuration
- KEY_ENTRY_AUTO_COMMIT_EN:
  - When defined: a digit press while count == 3 first performs the ENTER action on the current buffer. The new digit is then discarded; it does not start the next entry.
  - When undefined: that digit is ignored and only ENTER commits.
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then press 3, 5, 7 and ENTER (defaults):
  - data goes 003 -> 035 -> 357.
  - commit pulses once; tries = 1; result = 11; locked = 1.
  - Digit 1 afterwards leaves data = 357.
- Enter 1, 2, ENTER: result = 01, data = 000, tries = 1. Then enter 9, 9, 9, ENTER: result = 10, tries = 2.
- Press 4, 5, BACKSPACE: data = 004. BACKSPACE twice more leaves data = 000 with no underflow. ENTER on the empty buffer gives no commit and tries unchanged.
- Hold key 6 for 1000 cycles: exactly one press. key_deb = 0x0041 (two keys) gives no press. Keeping key 6 held through reset gives no press until release.
- Eleven wrong guesses: tries saturates at 9 and commit pulses 11 times. In DONE, CLEAR resets tries = 0, result = 00, locked = 0.
- With KEY_ENTRY_AUTO_COMMIT_EN defined: press 1, 2, 3, 4. This commits 123 (result 01), then data = 000 and tries = 1.
